spi_shift_ctrl: RTL and testbench
=================================

# spi_shift_ctrl

SPI master shift engine, directly downstream of the SPI clock divider. Drives `spi_cs` into the divider and the slave, watches the divided `spi_clk` that comes back, and shifts one `DATA_W`-bit word out on `mosi` while capturing one word from `miso`. SPI mode 0 (CPOL=0, CPHA=0). Runs entirely in the `m_clk` domain; `spi_clk` is treated as a data signal and edge-detected.

## Interface
- `DATA_W`, 8, word length in bits (≥2)
- `m_clk`  in  1  system clock; all state updates on its rising edge
- `nrst`  in  1  reset, synchronous, active-low
- `spi_clk`  in  1  divided SPI clock from the divider; also routed to the slave
- `start`  in  1  transfer request, sampled only in IDLE
- `tx_data`  in  DATA_W  word to send, captured in the cycle `start` is accepted
- `miso`  in  1  serial data from slave
- `spi_cs`  out  1  chip select, active-low; enables the divider
- `mosi`  out  1  serial data to slave
- `busy`  out  1  high from the accept cycle until `done`
- `done`  out  1  one-cycle pulse when `rx_data` is updated
- `rx_data`  out  DATA_W  last received word, held until next `done`

## Operation
- Edge detect: `spi_clk_q` is `spi_clk` registered on `m_clk` (reset 0). `rise = spi_clk & ~spi_clk_q`, `fall = ~spi_clk & spi_clk_q`.
- Bit counter `bit_cnt` is $clog2(DATA_W+1) bits wide and counts rising edges. It never wraps within a transfer.
- States: IDLE, SHIFT, END.
- IDLE: `spi_cs`=1, `busy`=0.
  - On `start`=1: `tx_sh`←`tx_data`, `mosi`←`tx_data[DATA_W-1]`, `spi_cs`←0, `busy`←1, `bit_cnt`←0, go to SHIFT.
- SHIFT:
  - On `rise`: `rx_sh`←{`rx_sh[DATA_W-2:0]`, `miso`}, `bit_cnt`←`bit_cnt`+1.
  - On `fall`, if `bit_cnt`==DATA_W: go to END. Otherwise `tx_sh` shifts left by one and `mosi`←the new MSB.
  - `rise` and `fall` cannot occur in the same cycle.
- END, one cycle: `spi_cs`←1, `busy`←0, `rx_data`←`rx_sh`, `done`←1, go to IDLE.
- `start` is ignored in SHIFT and in END. It is accepted no earlier than the cycle after `done`.
- Each transfer produces exactly 2·DATA_W `spi_clk` toggles, so `spi_clk` is low whenever the block is in IDLE. The divider holds its level while `spi_cs`=1.
- Reset (`nrst`=0 at a `m_clk` edge), from any state including mid-transfer:
  - state→IDLE; `spi_cs`=1, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0, `bit_cnt`=0, `tx_sh`=`rx_sh`=0, `spi_clk_q`=0.
  - No `done` is issued for the aborted word.

## Timing
- Accept: `spi_cs` falls and the first `mosi` bit is valid one `m_clk` after the `start`-sampling edge. This is before the first `spi_clk` rise.
- MOSI changes one `m_clk` after each `spi_clk` falling edge reaches this block. That is at least half an SPI period before the slave samples on the next rise.
- MISO is sampled one `m_clk` after each `spi_clk` rise, because of the `spi_clk_q` register. Slave data must stay valid for ≥2 `m_clk` after the rise.
- `done`/`rx_data` update: two `m_clk` after the last falling edge of `spi_clk` (one cycle for edge detect, one for END).
- `spi_cs` rises in the same cycle as `done`.
- Per-word duration ≈ 2·DATA_W half-periods of `spi_clk` plus 3 `m_clk`. The half-period is set by the divider (10 `m_clk`).

## Configuration
- `SPI_LSB_FIRST_EN` defined: bit order is LSB first. The first `mosi` bit is `tx_data[0]` and `tx_sh` shifts right. Received bits enter `rx_sh` at the MSB and shift right, so the first received bit ends in `rx_data[0]`.
- Undefined (default): MSB first on both `mosi` and `miso`, as described above.

## Test plan
- Reset: hold `nrst`=0 for 3 cycles → `spi_cs`=1, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0.
- Loopback (`miso`=`mosi`), `tx_data`=0xA5, `start` pulse → `spi_cs` low for 8 `spi_clk` rises; `mosi` sequence 1,0,1,0,0,1,0,1; single `done` pulse; `rx_data`=0xA5; `spi_clk` low after `spi_cs` rises.
- `miso` tied 1, `tx_data`=0x00 → `mosi` stays 0 throughout; `rx_data`=0xFF.
- `start` held high continuously with `tx_data`=0x3C, then 0xC3 → the second word starts only after `done`, with `spi_cs` high for ≥1 cycle between words; no bit lost; loopback returns 0x3C, then 0xC3.
- `nrst`=0 one cycle after the 3rd `spi_clk` rise → next cycle `spi_cs`=1, `busy`=0; no `done`; `rx_data`=0; a new `start` after reset completes a full 8-bit transfer.
- With `SPI_LSB_FIRST_EN`, loopback `tx_data`=0x01 → first `mosi` bit 1, the remaining bits 0; `rx_data`=0x01.

Source files
------------

// File: rtl/spi_shift_ctrl.sv
// SPI mode-0 master shift engine: edge-detects the divided spi_clk, shifts one word out on mosi
// and captures one from miso. Define SPI_LSB_FIRST_EN for LSB-first bit order (default MSB first).
module spi_shift_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              m_clk,
    input  logic              nrst,
    input  logic              spi_clk,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              spi_cs,
    output logic              mosi,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_END} state_t;

    state_t            state, state_nxt;
    logic              spi_clk_q;
    logic              rise, fall;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] tx_sh, rx_sh;
    logic [DATA_W-1:0] tx_next, rx_next;
    logic              mosi_next, mosi_first;
    logic              last_bit;

    assign rise     = spi_clk & ~spi_clk_q;
    assign fall     = ~spi_clk & spi_clk_q;
    assign last_bit = (bit_cnt == CW'(DATA_W));

`ifdef SPI_LSB_FIRST_EN
    assign mosi_first = tx_data[0];
    assign tx_next    = tx_sh >> 1;
    assign mosi_next  = tx_sh[1];
    assign rx_next    = {miso, rx_sh[DATA_W-1:1]};
`else
    assign mosi_first = tx_data[DATA_W-1];
    assign tx_next    = tx_sh << 1;
    assign mosi_next  = tx_sh[DATA_W-2];
    assign rx_next    = {rx_sh[DATA_W-2:0], miso};
`endif

    always_ff @(posedge m_clk) begin
        if (!nrst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SHIFT;
            S_SHIFT: if (fall && last_bit) state_nxt = S_END;
            S_END:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge m_clk) begin
        if (!nrst) begin
            spi_clk_q <= 1'b0;
            spi_cs    <= 1'b1;
            mosi      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rx_data   <= '0;
            bit_cnt   <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
        end else begin
            spi_clk_q <= spi_clk;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tx_sh   <= tx_data;
                        mosi    <= mosi_first;
                        spi_cs  <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    // The final fall only ends the word; the shifter is not advanced past the last bit.
                    if (rise) begin
                        rx_sh   <= rx_next;
                        bit_cnt <= bit_cnt + CW'(1);
                    end else if (fall && !last_bit) begin
                        tx_sh <= tx_next;
                        mosi  <= mosi_next;
                    end
                end
                S_END: begin
                    spi_cs  <= 1'b1;
                    busy    <= 1'b0;
                    rx_data <= rx_sh;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_shift_ctrl.sv
// Directed bench for spi_shift_ctrl with a behavioural clock divider (10 m_clk half-period)
// and optional miso loopback.
module tb_spi_shift_ctrl;
    localparam int DW = 8;

    logic          m_clk = 1'b0;
    logic          nrst = 1'b0;
    logic          spi_clk = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          miso;
    logic          spi_cs, mosi, busy, done;
    logic [DW-1:0] rx_data;

    logic loop = 1'b1;
    logic miso_fix = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   rises = 0;
    int   dones = 0;
    int   div_cnt = 0;
    logic prev_clk = 1'b0;
    logic mosi_hi = 1'b0;
    logic bits[$];

    assign miso = loop ? mosi : miso_fix;

    spi_shift_ctrl #(.DATA_W(DW)) dut (
        .m_clk(m_clk), .nrst(nrst), .spi_clk(spi_clk), .start(start), .tx_data(tx_data),
        .miso(miso), .spi_cs(spi_cs), .mosi(mosi), .busy(busy), .done(done), .rx_data(rx_data)
    );

    always #5 m_clk = ~m_clk;

    // Divider model: toggles every 10 m_clk while spi_cs is low, holds level otherwise.
    always @(posedge m_clk) begin
        if (!nrst) begin
            spi_clk <= 1'b0;
            div_cnt <= 0;
        end else if (spi_cs) begin
            div_cnt <= 0;
        end else if (div_cnt == 9) begin
            div_cnt <= 0;
            spi_clk <= ~spi_clk;
        end else begin
            div_cnt <= div_cnt + 1;
        end
    end

    always @(negedge m_clk) begin
        if (spi_clk && !prev_clk) begin
            rises = rises + 1;
            bits.push_back(mosi);
        end
        prev_clk = spi_clk;
        if (done) dones = dones + 1;
        if (!spi_cs && mosi) mosi_hi = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task automatic tick();
        @(negedge m_clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pack_bits();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < bits.size(); i++) begin
`ifdef SPI_LSB_FIRST_EN
            v = {bits[i], v[DW-1:1]};
`else
            v = {v[DW-2:0], bits[i]};
`endif
        end
        return v;
    endfunction

    task automatic test_reset();
        nrst = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        vectors++; if (spi_cs !== 1'b1) begin miscompares++; $display("FAIL reset_cs: got %b want 1", spi_cs); end
        vectors++; if (mosi !== 1'b0) begin miscompares++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx: got %h want 00", rx_data); end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_loopback();
        int d0;
        loop = 1'b1;
        tx_data = 8'hA5;
        bits.delete();
        rises = 0;
        d0 = dones;
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++; if (spi_cs !== 1'b0) begin miscompares++; $display("FAIL lb_accept_cs: got %b want 0", spi_cs); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL lb_accept_busy: got %b want 1", busy); end
        vectors++; if (mosi !== 1'b1) begin miscompares++; $display("FAIL lb_first_mosi: got %b want 1", mosi); end
        for (int i = 0; i < 400 && !done; i++) tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL lb_done_timeout: got %b want 1", done); end
        vectors++; if (rx_data !== 8'hA5) begin miscompares++; $display("FAIL lb_rx: got %h want a5", rx_data); end
        vectors++; if (spi_cs !== 1'b1) begin miscompares++; $display("FAIL lb_cs_at_done: got %b want 1", spi_cs); end
        vectors++; if (rises !== 8) begin miscompares++; $display("FAIL lb_rises: got %0d want 8", rises); end
        vectors++; if (pack_bits() !== 8'hA5) begin miscompares++; $display("FAIL lb_mosi_seq: got %h want a5", pack_bits()); end
        tick();
        vectors++; if (spi_clk !== 1'b0) begin miscompares++; $display("FAIL lb_clk_idle: got %b want 0", spi_clk); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL lb_done_pulse: got %b want 0", done); end
        repeat (5) tick();
        vectors++; if (dones - d0 !== 1) begin miscompares++; $display("FAIL lb_done_count: got %0d want 1", dones - d0); end
    endtask

    task automatic test_miso_ones();
        loop = 1'b0;
        miso_fix = 1'b1;
        tx_data = 8'h00;
        mosi_hi = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 400 && !done; i++) tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL ones_done_timeout: got %b want 1", done); end
        vectors++; if (rx_data !== 8'hFF) begin miscompares++; $display("FAIL ones_rx: got %h want ff", rx_data); end
        vectors++; if (mosi_hi !== 1'b0) begin miscompares++; $display("FAIL ones_mosi_low: got %b want 0", mosi_hi); end
        loop = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int d0;
        loop = 1'b1;
        tx_data = 8'h3C;
        bits.delete();
        d0 = dones;
        start = 1'b1;
        for (int i = 0; i < 10 && !busy; i++) tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_timeout: got %b want 1", busy); end
        tx_data = 8'hC3;
        for (int i = 0; i < 400 && !done; i++) tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_done1_timeout: got %b want 1", done); end
        vectors++; if (rx_data !== 8'h3C) begin miscompares++; $display("FAIL b2b_rx1: got %h want 3c", rx_data); end
        vectors++; if (spi_cs !== 1'b1) begin miscompares++; $display("FAIL b2b_cs_gap: got %b want 1", spi_cs); end
        vectors++; if (pack_bits() !== 8'h3C) begin miscompares++; $display("FAIL b2b_seq1: got %h want 3c", pack_bits()); end
        bits.delete();
        tick();
        vectors++; if (spi_cs !== 1'b0) begin miscompares++; $display("FAIL b2b_restart_cs: got %b want 0", spi_cs); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
        start = 1'b0;
        for (int i = 0; i < 400 && !done; i++) tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_done2_timeout: got %b want 1", done); end
        vectors++; if (rx_data !== 8'hC3) begin miscompares++; $display("FAIL b2b_rx2: got %h want c3", rx_data); end
        vectors++; if (bits.size() !== 8) begin miscompares++; $display("FAIL b2b_bits2: got %0d want 8", bits.size()); end
        vectors++; if (pack_bits() !== 8'hC3) begin miscompares++; $display("FAIL b2b_seq2: got %h want c3", pack_bits()); end
        tick();
        vectors++; if (dones - d0 !== 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 2", dones - d0); end
    endtask

    task automatic test_reset_mid();
        int d0;
        loop = 1'b1;
        tx_data = 8'h5A;
        rises = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && rises < 3; i++) tick();
        vectors++; if (rises !== 3) begin miscompares++; $display("FAIL mid_rise_timeout: got %0d want 3", rises); end
        d0 = dones;
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        vectors++; if (spi_cs !== 1'b1) begin miscompares++; $display("FAIL mid_cs: got %b want 1", spi_cs); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
        vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL mid_rx: got %h want 00", rx_data); end
        repeat (30) tick();
        vectors++; if (dones !== d0) begin miscompares++; $display("FAIL mid_no_done: got %0d want %0d", dones, d0); end
        tx_data = 8'h96;
        bits.delete();
        rises = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 400 && !done; i++) tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL mid_after_done_timeout: got %b want 1", done); end
        vectors++; if (rx_data !== 8'h96) begin miscompares++; $display("FAIL mid_after_rx: got %h want 96", rx_data); end
        vectors++; if (rises !== 8) begin miscompares++; $display("FAIL mid_after_rises: got %0d want 8", rises); end
        tick();
    endtask

    task automatic test_bit_order();
        logic first_exp;
`ifdef SPI_LSB_FIRST_EN
        first_exp = 1'b1;
`else
        first_exp = 1'b0;
`endif
        loop = 1'b1;
        tx_data = 8'h01;
        bits.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 400 && !done; i++) tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL order_done_timeout: got %b want 1", done); end
        vectors++; if (bits.size() !== 8) begin miscompares++; $display("FAIL order_bits: got %0d want 8", bits.size()); end
        if (bits.size() > 0) begin
            vectors++; if (bits[0] !== first_exp) begin miscompares++; $display("FAIL order_first_bit: got %b want %b", bits[0], first_exp); end
        end
        vectors++; if (pack_bits() !== 8'h01) begin miscompares++; $display("FAIL order_seq: got %h want 01", pack_bits()); end
        vectors++; if (rx_data !== 8'h01) begin miscompares++; $display("FAIL order_rx: got %h want 01", rx_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_miso_ones();
        test_back_to_back();
        test_reset_mid();
        test_bit_order();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
